// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encodings and
// the iteration-counter width helper.
package seq_divider_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Wide enough to hold N itself, so the counter never wraps mid-division.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor at N+1 bits, and keep or restore the partial remainder.
module div_step #(
    parameter int N = 4
) (
    input  logic [N:0]   rem,
    input  logic         dvd_msb,
    input  logic [N-1:0] dvs,
    output logic [N:0]   rem_next,
    output logic         qbit
);

    logic [N:0] t;
    logic [N:0] d;

    // t < 2*dvs, so the extra bit makes d[N] an exact borrow flag.
    assign t        = {rem[N-1:0], dvd_msb};
    assign d        = t - {1'b0, dvs};
    assign qbit     = ~d[N];
    assign rem_next = qbit ? d : t;

endmodule

// File: rtl/seq_divider.sv
// Unsigned sequential restoring divider, one quotient bit per clock, with a
// start/done handshake and a divide-by-zero short path.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Q,
    output logic [N-1:0] Rm,
    output logic         dz
);

    localparam int CW = cnt_w(N);

    logic [1:0]    state;
    logic [N-1:0]  dvd;
    logic [N-1:0]  dvs;
    logic [N:0]    rem;
    logic [N:0]    rem_next;
    logic          qbit;
    logic [CW-1:0] cnt;
    logic [N-1:0]  dvd_next;

    div_step #(.N(N)) u_step (
        .rem      (rem),
        .dvd_msb  (dvd[N-1]),
        .dvs      (dvs),
        .rem_next (rem_next),
        .qbit     (qbit)
    );

    // Dividend bits leave at the top while quotient bits enter at the bottom.
    assign dvd_next = {dvd[N-2:0], qbit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            Q     <= '0;
            Rm    <= '0;
            dz    <= 1'b0;
            dvd   <= '0;
            dvs   <= '0;
            rem   <= '0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (B != '0) begin
                            state <= ST_RUN;
                            busy  <= 1'b1;
                            dvd   <= A;
                            dvs   <= B;
                            rem   <= '0;
                            cnt   <= '0;
                        end else begin
                            // Divide by zero completes immediately without iterating.
                            state <= ST_DONE;
                            Q     <= '1;
                            Rm    <= A;
                            dz    <= 1'b1;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    rem <= rem_next;
                    dvd <= dvd_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        Q     <= dvd_next;
                        Rm    <= rem_next[N-1:0];
                        dz    <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
